// File: rtl/parking_gate_ctrl.sv
// Single-lane parking entry gate: PIN keypad, lockout, tailgate alarm, lot occupancy, gate timeout.
// Latency: every output is registered or decoded from registered state, so it changes on the edge that samples its cause.
// Backpressure: none; sensor and keypad inputs are sampled every cycle. Optional macro PIN_RELOAD_EN adds a runtime PIN register.
module parking_gate_ctrl #(
    parameter int                CODE_W       = 16,
    parameter logic [CODE_W-1:0] PIN          = 16'h5990,
    parameter int                MAX_TRIES    = 3,
    parameter int                CAPACITY     = 8,
    parameter int                CNT_W        = 4,
    parameter int                GATE_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vehicle_arrival,
    input  logic              vehicle_left,
    input  logic              vehicle_exit,
    input  logic [CODE_W-1:0] code,
    input  logic              code_ack,
`ifdef PIN_RELOAD_EN
    input  logic              pin_we,
    input  logic [CODE_W-1:0] pin_wdata,
`endif
    output logic              gate_open,
    output logic              wrong_pin,
    output logic              lockout,
    output logic              block_alarm,
    output logic              lot_full,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int               TMR_W   = $clog2(GATE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
    localparam logic [3:0]       TRY_MAX = 4'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(GATE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PIN = 3'd1,
        OPEN     = 3'd2,
        LOCKOUT  = 3'd3,
        BLOCK    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         tries_q, tries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               full_q, full_d;
    logic               wrong_q, wrong_d;
    logic               ack_q;
    logic               ack_rise;
    logic               pin_ok;
    logic               entry;

`ifdef PIN_RELOAD_EN
    logic [CODE_W-1:0]  pin_q;

    // Runtime PIN register; writes are accepted only while the gate is idle.
    always_ff @(posedge clk) begin
        if (!rst)
            pin_q <= PIN;
        else if (pin_we && state_q == IDLE)
            pin_q <= pin_wdata;
    end

    assign pin_ok = (code == pin_q);
`else
    assign pin_ok = (code == PIN);
`endif

    assign ack_rise = code_ack & ~ack_q;
    // A car counts as entered only when it clears the sensor with nobody behind it.
    assign entry    = (state_q == OPEN) & vehicle_left & ~vehicle_arrival;

    // State, counters and registered flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tries_q <= '0;
            timer_q <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            wrong_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            wrong_q <= wrong_d;
            ack_q   <= code_ack;
        end
    end

    // Gate FSM next state, attempt counter and open timer.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        timer_d = timer_q;
        wrong_d = wrong_q;
        case (state_q)
            IDLE: begin
                if (vehicle_arrival && !full_q)
                    state_d = WAIT_PIN;
            end
            WAIT_PIN: begin
                if (ack_rise && pin_ok) begin
                    state_d = OPEN;
                    tries_d = '0;
                    wrong_d = 1'b0;
                    timer_d = '0;
                end else if (ack_rise) begin
                    tries_d = tries_q + 4'd1;
                    wrong_d = 1'b1;
                    if (tries_q + 4'd1 == TRY_MAX)
                        state_d = LOCKOUT;
                end else if (!vehicle_arrival) begin
                    state_d = IDLE;
                    tries_d = '0;
                    wrong_d = 1'b0;
                end
            end
            OPEN: begin
                timer_d = timer_q + TMR_W'(1);
                if (vehicle_left && vehicle_arrival)
                    state_d = BLOCK;
                else if (vehicle_left)
                    state_d = IDLE;
                else if (timer_q == TMR_END)
                    state_d = IDLE;
            end
            LOCKOUT: begin
                // The supervisor unlock also counts as the latest attempt, so wrong_pin clears.
                if (ack_rise && pin_ok) begin
                    state_d = IDLE;
                    tries_d = '0;
                    wrong_d = 1'b0;
                end
            end
            BLOCK: begin
                if (ack_rise && pin_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy: saturating up on entry, down on exit, simultaneous events cancel.
    always_comb begin
        occ_d = occ_q;
        if (entry && !vehicle_exit) begin
            if (occ_q != CAP)
                occ_d = occ_q + CNT_W'(1);
        end else if (!entry && vehicle_exit) begin
            if (occ_q != '0)
                occ_d = occ_q - CNT_W'(1);
        end
        full_d = (occ_d == CAP);
    end

    assign gate_open   = (state_q == OPEN);
    assign lockout     = (state_q == LOCKOUT);
    assign block_alarm = (state_q == BLOCK);
    assign wrong_pin   = wrong_q | (state_q == LOCKOUT);
    assign lot_full    = full_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with default parameters.
// Inputs change #1 after a rising edge; outputs are observed at the same point.
// Build with PIN_RELOAD_EN defined to also exercise the runtime PIN register.
module tb_parking_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vehicle_arrival;
    logic        vehicle_left;
    logic        vehicle_exit;
    logic [15:0] code;
    logic        code_ack;
`ifdef PIN_RELOAD_EN
    logic        pin_we;
    logic [15:0] pin_wdata;
`endif
    logic        gate_open;
    logic        wrong_pin;
    logic        lockout;
    logic        block_alarm;
    logic        lot_full;
    logic [3:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parking_gate_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .vehicle_arrival (vehicle_arrival),
        .vehicle_left    (vehicle_left),
        .vehicle_exit    (vehicle_exit),
        .code            (code),
        .code_ack        (code_ack),
`ifdef PIN_RELOAD_EN
        .pin_we          (pin_we),
        .pin_wdata       (pin_wdata),
`endif
        .gate_open       (gate_open),
        .wrong_pin       (wrong_pin),
        .lockout         (lockout),
        .block_alarm     (block_alarm),
        .lot_full        (lot_full),
        .occupancy       (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a code with a rising code_ack; the edge that samples it is consumed here.
    task automatic press(input logic [15:0] c);
        code     = c;
        code_ack = 1'b1;
        tick();
    endtask

    // Drop code_ack for one edge so the next press is a fresh rising edge.
    task automatic rel();
        code_ack = 1'b0;
        tick();
    endtask

    // Full admission of one car: arrive, correct PIN, car drives through.
    task automatic enter_car();
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        code_ack        = 1'b0;
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b1;
        tick();
        vehicle_left    = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b0;
        vehicle_exit    = 1'b0;
        code            = 16'h0000;
        code_ack        = 1'b0;
`ifdef PIN_RELOAD_EN
        pin_we          = 1'b0;
        pin_wdata       = 16'h0000;
`endif
        repeat (5) tick();
        chk("rst_gate", gate_open, 0);
        chk("rst_wrong", wrong_pin, 0);
        chk("rst_lock", lockout, 0);
        chk("rst_block", block_alarm, 0);
        chk("rst_full", lot_full, 0);
        chk("rst_occ", occupancy, 0);
        rst = 1'b1;
        tick();

        // 1: basic admission
        vehicle_arrival = 1'b1;
        tick();
        chk("t1_wait_gate", gate_open, 0);
        press(16'h5990);
        chk("t1_open", gate_open, 1);
        code_ack        = 1'b0;
        vehicle_left    = 1'b1;
        vehicle_arrival = 1'b0;
        tick();
        vehicle_left    = 1'b0;
        chk("t1_closed", gate_open, 0);
        chk("t1_occ", occupancy, 1);

        // 2: two wrong codes then walk away; tries must reset
        vehicle_arrival = 1'b1;
        tick();
        press(16'h1234);
        chk("t2_wrong1", wrong_pin, 1);
        chk("t2_nolock1", lockout, 0);
        rel();
        press(16'h3145);
        chk("t2_wrong2", wrong_pin, 1);
        chk("t2_nolock2", lockout, 0);
        rel();
        vehicle_arrival = 1'b0;
        tick();
        chk("t2_wrong_clr", wrong_pin, 0);
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("t2_open", gate_open, 1);
        chk("t2_wrong_ok", wrong_pin, 0);
        rel();
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b1;
        tick();
        vehicle_left    = 1'b0;
        chk("t2_occ", occupancy, 2);

        // 3: lockout after three wrong codes, supervisor unlock
        vehicle_arrival = 1'b1;
        tick();
        press(16'h1234);
        rel();
        press(16'h3145);
        chk("t3_nolock2", lockout, 0);
        rel();
        press(16'h4321);
        chk("t3_lock", lockout, 1);
        chk("t3_lock_wrong", wrong_pin, 1);
        chk("t3_lock_gate", gate_open, 0);
        rel();
        press(16'h5555);
        chk("t3_lock_hold", lockout, 1);
        rel();
        vehicle_arrival = 1'b0;
        press(16'h5990);
        chk("t3_unlock", lockout, 0);
        chk("t3_unlock_gate", gate_open, 0);
        rel();
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("t3_idle_reopen", gate_open, 1);
        rel();
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b1;
        tick();
        vehicle_left    = 1'b0;
        chk("t3_occ", occupancy, 3);

        // 4: tailgating
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("t4_open", gate_open, 1);
        rel();
        vehicle_left = 1'b1;
        tick();
        vehicle_left    = 1'b0;
        vehicle_arrival = 1'b0;
        chk("t4_block", block_alarm, 1);
        chk("t4_gate", gate_open, 0);
        chk("t4_occ", occupancy, 3);
        press(16'h1234);
        chk("t4_block_hold", block_alarm, 1);
        rel();
        press(16'h5990);
        chk("t4_clear", block_alarm, 0);
        rel();

        // 5: fill the lot, full behaviour, exits and saturation
        for (int i = 0; i < 5; i++) enter_car();
        chk("t5_occ8", occupancy, 8);
        chk("t5_full", lot_full, 1);
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("t5_full_gate", gate_open, 0);
        rel();
        vehicle_arrival = 1'b0;
        vehicle_exit    = 1'b1;
        tick();
        vehicle_exit    = 1'b0;
        chk("t5_occ7", occupancy, 7);
        chk("t5_notfull", lot_full, 0);
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        rel();
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b1;
        vehicle_exit    = 1'b1;
        tick();
        vehicle_left    = 1'b0;
        vehicle_exit    = 1'b0;
        chk("t5_same_cycle", occupancy, 7);
        chk("t5_same_gate", gate_open, 0);
        vehicle_exit = 1'b1;
        repeat (7) tick();
        chk("t5_occ0", occupancy, 0);
        tick();
        vehicle_exit = 1'b0;
        chk("t5_occ0_sat", occupancy, 0);

        // 6: gate timeout after exactly 16 open cycles
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("t6_open", gate_open, 1);
        code_ack        = 1'b0;
        vehicle_arrival = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("t6_still_open_%0d", i), gate_open, 1);
        end
        tick();
        chk("t6_timeout", gate_open, 0);
        chk("t6_occ", occupancy, 0);

        // reset while the gate is open clears state and occupancy
        enter_car();
        chk("rm_occ1", occupancy, 1);
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("rm_open", gate_open, 1);
        rst = 1'b0;
        tick();
        chk("rm_gate", gate_open, 0);
        chk("rm_occ", occupancy, 0);
        rst             = 1'b1;
        code_ack        = 1'b0;
        vehicle_arrival = 1'b0;
        tick();

`ifdef PIN_RELOAD_EN
        pin_we    = 1'b1;
        pin_wdata = 16'hABCD;
        tick();
        pin_we    = 1'b0;
        vehicle_arrival = 1'b1;
        tick();
        press(16'h5990);
        chk("pr_old_rejected", wrong_pin, 1);
        chk("pr_old_gate", gate_open, 0);
        rel();
        press(16'hABCD);
        chk("pr_new_open", gate_open, 1);
        rel();
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b1;
        tick();
        vehicle_left    = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
